// File: rtl/interval_ctrl_if.sv
// Control bundle between the interval sequencer, its requester
// and the downstream loadable up-counter.
interface interval_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             stop;
    logic             hold;
    logic             mode;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] cnt_out;
    logic             cnt_rst;
    logic             cnt_load;
    logic             cnt_enab;
    logic [WIDTH-1:0] cnt_in;
    logic             tick;
    logic             busy;
    logic             err;

    modport master (
        output start,
        output stop,
        output hold,
        output mode,
        output period,
        output cnt_out,
        input  cnt_rst,
        input  cnt_load,
        input  cnt_enab,
        input  cnt_in,
        input  tick,
        input  busy,
        input  err
    );

    modport slave (
        input  start,
        input  stop,
        input  hold,
        input  mode,
        input  period,
        input  cnt_out,
        output cnt_rst,
        output cnt_load,
        output cnt_enab,
        output cnt_in,
        output tick,
        output busy,
        output err
    );
endinterface

// File: rtl/interval_ctrl.sv
// Interval sequencer: drives an external up-counter and watches its
// value to produce periodic or one-shot ticks.
module interval_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    interval_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE =
        {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_d;
    logic             mode_q;
    logic             mode_d;
    logic             err_q;
    logic             err_d;

    logic [WIDTH-1:0] lim;
    logic             term;
    logic             over;
    logic             accept;

    logic             cnt_rst;
    logic             cnt_load;
    logic             cnt_enab;
    logic             tick;
    logic             busy;

    // period_q is never 0 in RUN, so lim cannot underflow there
    assign lim    = period_q - ONE;
    assign term   = bus.cnt_out == lim;
    assign over   = bus.cnt_out > lim;
    assign accept = bus.start && (bus.period != '0);

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        mode_d   = mode_q;
        err_d    = err_q;
        cnt_rst  = 1'b1;
        cnt_load = 1'b0;
        cnt_enab = 1'b0;
        tick     = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = RUN;
                    period_d = bus.period;
                    mode_d   = bus.mode;
                    err_d    = 1'b0;
                end
            end
            RUN: begin
                cnt_rst = 1'b0;
                busy    = 1'b1;
                if (over) begin
                    err_d = 1'b1;
                end
                // a term seen under hold simply waits for hold to drop
                if (!bus.hold) begin
                    if (term) begin
                        tick = 1'b1;
                        if (mode_q) begin
                            cnt_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_enab = 1'b1;
                    end
                end
                if (bus.stop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
        end
    end

    assign bus.cnt_rst  = cnt_rst;
    assign bus.cnt_load = cnt_load;
    assign bus.cnt_enab = cnt_enab;
    assign bus.cnt_in   = '0;
    assign bus.tick     = tick;
    assign bus.busy     = busy;
    assign bus.err      = err_q;
endmodule

// File: doc/interval_ctrl.md
# interval_ctrl

Control stage that sits directly upstream of the loadable up-counter and drives its `rst`, `load`, `cnt_in` and `enab` inputs. It watches the counter's `cnt_out` to generate a programmable periodic or one-shot interval tick. This turns the bare counter into an interval timer for the rest of the design. The block holds no count register of its own: the count lives in the counter, and this block owns only the sequencing.

## Interface
- `WIDTH`, 5, counter width; must equal the downstream counter's `WIDTH`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `start`  in  1  start request; sampled only in IDLE
- `stop`  in  1  abort request; sampled only in RUN
- `hold`  in  1  pause counting while in RUN
- `mode`  in  1  0 = one-shot, 1 = periodic; latched on accepted start
- `period`  in  WIDTH  interval length P in cycles; latched on accepted start
- `cnt_out`  in  WIDTH  counter value fed back from the counter
- `cnt_rst`  out  1  to counter `rst` (active-high, synchronous in counter)
- `cnt_load`  out  1  to counter `load`
- `cnt_enab`  out  1  to counter `enab`
- `cnt_in`  out  WIDTH  to counter `cnt_in`; constant 0
- `tick`  out  1  one-cycle pulse at the end of each interval
- `busy`  out  1  high in RUN
- `err`  out  1  sticky: counter feedback out of range

## Operation
- The state register is the only FSM storage, with states IDLE and RUN. `period_q`, `mode_q` and `err` are also registered.
- Reset (`rst`=0) forces state=IDLE, `period_q`=0, `mode_q`=0, `err`=0 immediately.
- Outputs are combinational from state, `period_q`, `mode_q`, `hold`, `stop` and `cnt_out`.
- IDLE:
  - `cnt_rst`=1, `cnt_load`=0, `cnt_enab`=0, `busy`=0, `tick`=0, so the counter holds 0.
  - `start`=1 with `period`!=0 latches `period_q`=`period` and `mode_q`=`mode`, clears `err`, and moves to RUN.
  - `start`=1 with `period`=0 is ignored: state stays IDLE and `err` is unchanged.
- RUN:
  - `busy`=1 and `cnt_rst`=0.
  - The terminal condition `term` is `cnt_out == period_q-1` (WIDTH-bit compare, no wrap).
  - `hold`=1: `cnt_enab`=0, `cnt_load`=0, `tick`=0, and the counter freezes. A `term` during hold is deferred until hold drops.
  - `hold`=0 and not `term`: `cnt_enab`=1.
  - `hold`=0 and `term`: `tick`=1 and `cnt_enab`=0.
    - If `mode_q`=1, `cnt_load`=1 (counter goes to 0) and the state stays RUN.
    - If `mode_q`=0, the state goes to IDLE.
  - `stop`=1 moves the state to IDLE at the next edge, whatever the mode. A `tick` that is due in the same cycle is still asserted.
  - `start` is ignored in RUN; there is no retrigger.
  - `cnt_out > period_q-1` sets `err`=1. The state is unaffected and the `term` compare is unchanged, so a runaway counter wraps naturally.
- `cnt_in` is tied to all-zeros.
- P = 2^WIDTH-1 (all ones) is legal; `term` occurs at `cnt_out` = 2^WIDTH-2.

## Timing
- Edge E0 accepts the start; RUN begins in cycle 1. The counter reads 0 in cycle 1 because it was held by `cnt_rst`.
- With no hold, `tick` is high in cycle P, when `cnt_out`=P-1. In periodic mode the next ticks fall in cycles 2P, 3P, and so on, so the tick spacing is exactly P cycles.
- P=1 in periodic mode gives `tick` every cycle from cycle 1, with `cnt_load`=1 every cycle.
- Each hold cycle delays all subsequent ticks by one cycle.
- After a one-shot tick or a stop, the block is in IDLE the next cycle and the counter reads 0 one cycle after that. A start accepted in that first IDLE cycle still sees the counter at 0 at the start of RUN.
- Asynchronous reset mid-RUN drops `busy` and `tick` at once and asserts `cnt_rst`. The counter clears on its next clock edge.
- The feedback path runs combinationally from `cnt_out` through the compare to `cnt_load`/`cnt_enab`, and must close in one cycle.

## Test plan
- Reset, then start with P=5, mode=1 and no hold -> `tick` in cycles 5, 10, 15. `cnt_out` runs 0..4 then repeats, and `busy`=1 throughout.
- Start with P=3, mode=0 -> single `tick` in cycle 3, `busy` low from cycle 4, `cnt_out`=0 from cycle 5. Further cycles produce no ticks.
- P=5 periodic with `hold` high in cycles 2–3 -> ticks in cycles 7 and 12, and `cnt_out` frozen at 1 during the hold.
- Start with `period`=0 -> the block remains IDLE, with `busy`=0 and no tick. Then P=1 periodic -> `tick` every cycle.
- `stop` coincident with `term` (P=4 periodic, stop in cycle 4) -> `tick` high in cycle 4 and IDLE in cycle 5. Separately, `rst`=0 asserted mid-RUN -> `busy`/`tick`=0 immediately and `cnt_rst`=1.
- Force `cnt_out`=7 while P=4 -> `err` sets and stays set; the next accepted start clears it to 0.
